// File: rtl/singly_linked_list_ctrl_if.sv
// Op request/response and list status bundle for singly_linked_list_ctrl.
interface singly_linked_list_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_NODE   = 8
);
    localparam int AW = $clog2(MAX_NODE + 1);

    logic [2:0]            op;
    logic                  op_start;
    logic [DATA_WIDTH-1:0] data_in;
    logic [AW-1:0]         addr_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic [AW-1:0]         addr_out;
    logic [AW-1:0]         next_node_addr;
    logic [AW-1:0]         index_out;
    logic                  op_done;
    logic                  fault;
    logic [AW-1:0]         head;
    logic [AW-1:0]         tail;
    logic [AW-1:0]         length;
    logic                  full;
    logic                  empty;

    modport master (
        output op, op_start, data_in, addr_in,
        input  data_out, addr_out, next_node_addr, index_out,
        input  op_done, fault, head, tail, length, full, empty
    );

    modport slave (
        input  op, op_start, data_in, addr_in,
        output data_out, addr_out, next_node_addr, index_out,
        output op_done, fault, head, tail, length, full, empty
    );
endinterface

// File: rtl/singly_linked_list_ctrl.sv
// Singly-linked-list engine over an internal node RAM.
// Define SLL_FIND_VALUE_EN to enable the FIND_VALUE op (op 6).
module singly_linked_list_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_NODE   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_rst,
    singly_linked_list_ctrl_if.slave bus
);
    localparam int AW = $clog2(MAX_NODE + 1);
    localparam int IW = (MAX_NODE > 1) ? $clog2(MAX_NODE) : 1;
    localparam logic [AW-1:0] NULL_ADDR = '1;
    localparam logic [AW-1:0] CAP = AW'(MAX_NODE);

    localparam logic [2:0] OP_READ  = 3'd0;
    localparam logic [2:0] OP_INS   = 3'd1;
    localparam logic [2:0] OP_PUSHB = 3'd2;
    localparam logic [2:0] OP_PUSHF = 3'd3;
    localparam logic [2:0] OP_DELV  = 3'd4;
    localparam logic [2:0] OP_DELI  = 3'd5;
    localparam logic [2:0] OP_FIND  = 3'd6;

    typedef enum logic [2:0] {
        IDLE, ALLOC, TRAVERSE, LINK, DONE, FAULT
    } state_e;

    state_e state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] val_q, val_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [AW-1:0]         cur_q, cur_d;
    logic [AW-1:0]         prev_q, prev_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         head_q, head_d;
    logic [AW-1:0]         tail_q, tail_d;
    logic [AW-1:0]         len_q, len_d;
    logic [MAX_NODE-1:0]   node_vld_q, node_vld_d;
    logic [DATA_WIDTH-1:0] node_data_q [MAX_NODE];
    logic [DATA_WIDTH-1:0] node_data_d [MAX_NODE];
    logic [AW-1:0]         node_next_q [MAX_NODE];
    logic [AW-1:0]         node_next_d [MAX_NODE];
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [AW-1:0]         aout_q, aout_d;
    logic [AW-1:0]         nout_q, nout_d;
    logic [AW-1:0]         iout_q, iout_d;
    logic                  done_q, done_d;
    logic                  fault_q, fault_d;

    logic          full, empty, front, hit, cur_nul;
    logic [AW-1:0] free;
    logic [IW-1:0] cur_ix, prev_ix, tail_ix, free_ix, idx_ix;

    assign full    = (len_q == CAP);
    assign empty   = (len_q == '0);
    assign cur_nul = (cur_q == NULL_ADDR);
    assign cur_ix  = cur_q[IW-1:0];
    assign prev_ix = prev_q[IW-1:0];
    assign tail_ix = tail_q[IW-1:0];
    assign free_ix = free[IW-1:0];
    assign idx_ix  = idx_q[IW-1:0];

    // Lowest-numbered free node wins.
    always_comb begin
        free = '0;
        for (int i = MAX_NODE - 1; i >= 0; i--)
            if (!node_vld_q[i]) free = AW'(i);
    end

    always_comb begin
        case (op_q)
            OP_DELI: hit = (cnt_q == idx_q);
            OP_INS:  hit = (cnt_q == idx_q - AW'(1));
            default: hit = !cur_nul && (node_data_q[cur_ix] == val_q);
        endcase
    end

    always_comb begin
        state_d = state_q; op_d = op_q; val_d = val_q; idx_d = idx_q;
        cur_d = cur_q; prev_d = prev_q; cnt_d = cnt_q;
        head_d = head_q; tail_d = tail_q; len_d = len_q;
        node_vld_d = node_vld_q;
        node_data_d = node_data_q;
        node_next_d = node_next_q;
        dout_d = dout_q; aout_d = aout_q; nout_d = nout_q; iout_d = iout_q;
        done_d = 1'b0; fault_d = 1'b0; front = 1'b0;

        case (state_q)
            IDLE: if (bus.op_start) begin
                op_d = bus.op; val_d = bus.data_in; idx_d = bus.addr_in;
                cur_d = head_q; prev_d = NULL_ADDR; cnt_d = '0;
                case (bus.op)
                    OP_PUSHB, OP_PUSHF: state_d = ALLOC;
                    OP_INS: state_d = (full || bus.addr_in == '0 ||
                                       bus.addr_in >= len_q) ? ALLOC : TRAVERSE;
                    OP_DELV: state_d = TRAVERSE;
                    OP_DELI: state_d = (bus.addr_in >= len_q) ? LINK : TRAVERSE;
`ifdef SLL_FIND_VALUE_EN
                    OP_FIND: state_d = TRAVERSE;
`endif
                    default: state_d = LINK;
                endcase
            end
            ALLOC: begin
                done_d = 1'b1;
                if (full || (op_q == OP_INS && idx_q > len_q)) begin
                    fault_d = 1'b1;
                    state_d = FAULT;
                end else begin
                    front = (op_q == OP_PUSHF) || (op_q == OP_INS && idx_q == '0);
                    node_vld_d[free_ix]  = 1'b1;
                    node_data_d[free_ix] = val_q;
                    if (front) begin
                        node_next_d[free_ix] = head_q;
                        nout_d = head_q;
                        head_d = free;
                        if (empty) tail_d = free;
                    end else begin
                        node_next_d[free_ix] = NULL_ADDR;
                        nout_d = NULL_ADDR;
                        if (empty) head_d = free;
                        else node_next_d[tail_ix] = free;
                        tail_d = free;
                    end
                    len_d = len_q + AW'(1);
                    dout_d = val_q; aout_d = free;
                    state_d = DONE;
                end
            end
            TRAVERSE: begin
                if (hit && !cur_nul) begin
                    done_d = 1'b1;
                    state_d = DONE;
                    aout_d = cur_q;
                    dout_d = node_data_q[cur_ix];
                    nout_d = node_next_q[cur_ix];
                    if (op_q == OP_INS) begin
                        // cur is node i-1; splice the new node after it.
                        node_vld_d[free_ix]  = 1'b1;
                        node_data_d[free_ix] = val_q;
                        node_next_d[free_ix] = node_next_q[cur_ix];
                        node_next_d[cur_ix]  = free;
                        len_d = len_q + AW'(1);
                        dout_d = val_q; aout_d = free;
                    end else if (op_q == OP_FIND) begin
`ifdef SLL_FIND_VALUE_EN
                        iout_d = cnt_q;
`endif
                    end else begin
                        node_vld_d[cur_ix] = 1'b0;
                        if (prev_q == NULL_ADDR) head_d = node_next_q[cur_ix];
                        else node_next_d[prev_ix] = node_next_q[cur_ix];
                        if (cur_q == tail_q) tail_d = prev_q;
                        len_d = len_q - AW'(1);
                    end
                end else if (cur_nul) begin
                    done_d = 1'b1; fault_d = 1'b1;
                    state_d = FAULT;
                end else begin
                    prev_d = cur_q;
                    cur_d = node_next_q[cur_ix];
                    cnt_d = cnt_q + AW'(1);
                end
            end
            LINK: begin
                done_d = 1'b1;
                if (op_q == OP_READ && idx_q < CAP && node_vld_q[idx_ix]) begin
                    dout_d = node_data_q[idx_ix];
                    nout_d = node_next_q[idx_ix];
                    aout_d = idx_q;
                    state_d = DONE;
                end else begin
                    fault_d = 1'b1;
                    state_d = FAULT;
                end
            end
            default: state_d = IDLE;
        endcase

        if (sync_rst) begin
            state_d = IDLE; op_d = '0; val_d = '0; idx_d = '0;
            cur_d = NULL_ADDR; prev_d = NULL_ADDR; cnt_d = '0;
            head_d = NULL_ADDR; tail_d = NULL_ADDR; len_d = '0;
            node_vld_d = '0;
            dout_d = '0; aout_d = '0; nout_d = '0; iout_d = '0;
            done_d = 1'b0; fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE; op_q <= '0; val_q <= '0; idx_q <= '0;
            cur_q <= NULL_ADDR; prev_q <= NULL_ADDR; cnt_q <= '0;
            head_q <= NULL_ADDR; tail_q <= NULL_ADDR; len_q <= '0;
            node_vld_q <= '0;
            dout_q <= '0; aout_q <= '0; nout_q <= '0; iout_q <= '0;
            done_q <= 1'b0; fault_q <= 1'b0;
        end else begin
            state_q <= state_d; op_q <= op_d; val_q <= val_d; idx_q <= idx_d;
            cur_q <= cur_d; prev_q <= prev_d; cnt_q <= cnt_d;
            head_q <= head_d; tail_q <= tail_d; len_q <= len_d;
            node_vld_q <= node_vld_d;
            dout_q <= dout_d; aout_q <= aout_d; nout_q <= nout_d; iout_q <= iout_d;
            done_q <= done_d; fault_q <= fault_d;
        end
    end

    // Payload/link storage is only read through valid nodes, so it needs no reset.
    always_ff @(posedge clk) begin
        node_data_q <= node_data_d;
        node_next_q <= node_next_d;
    end

    assign bus.data_out       = dout_q;
    assign bus.addr_out       = aout_q;
    assign bus.next_node_addr = nout_q;
    assign bus.index_out      = iout_q;
    assign bus.op_done        = done_q;
    assign bus.fault          = fault_q;
    assign bus.head           = head_q;
    assign bus.tail           = tail_q;
    assign bus.length         = len_q;
    assign bus.full           = full;
    assign bus.empty          = empty;
endmodule
